// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 timing constants for the sync generator, the renderer and
// the divider top level, plus a small helper that maps a logical "sync active"
// flag onto the physical pin level for a given polarity.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 640x480 uses negative (active-low) sync pulses.
    localparam logic VGA_SYNC_POL = 1'b0;

    localparam int VGA_CW = 10;

    // Pin level for a sync output: pol when active, ~pol otherwise.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One axis (horizontal or vertical) of the raster: an enable-driven counter
// that wraps from TOTAL-1 to 0, plus decodes of the active and sync windows.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high; count returns to 0
//   en_i         in   advance the count by one this clk
//   count_o      out  current position on this axis
//   wrap_o       out  count is at TOTAL-1 (next enabled step returns to 0)
//   in_active_o  out  count < ACTIVE
//   in_sync_o    out  SYNC_START <= count < SYNC_END
// ---------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int CW         = 10,
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          wrap_o,
    output logic          in_active_o,
    output logic          in_sync_o
);

    generate
        if ((2 ** CW) < TOTAL) begin : g_cw_too_small
            $error("vga_axis_counter: CW=%0d cannot hold TOTAL=%0d", CW, TOTAL);
        end
    endgenerate

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    // One extra bit so window bounds equal to 2**CW still compare correctly.
    localparam logic [CW:0]   ACT_L   = (CW + 1)'(ACTIVE);
    localparam logic [CW:0]   SYNC_LO = (CW + 1)'(SYNC_START);
    localparam logic [CW:0]   SYNC_HI = (CW + 1)'(SYNC_END);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW:0]   count_x;

    assign wrap_o  = (count_q == LAST);
    assign count_x = {1'b0, count_q};

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign in_active_o = (count_x < ACT_L);
    assign in_sync_o   = (count_x >= SYNC_LO) && (count_x < SYNC_HI);

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// 640x480@60 VGA timing generator. The 25 MHz pixel clock arrives as a level
// sampled in the 100 MHz clk domain; each rising edge of it is one pixel tick.
// The first tick after reset only arms the generator (position stays at 0,0
// but the strobes fire), later ticks advance x/y across the raster.
//
// Ports
//   clk          in   100 MHz system clock
//   reset        in   synchronous, active-high
//   pix_clk      in   divided pixel clock level
//   hsync        out  horizontal sync, pin level per SYNC_POL
//   vsync        out  vertical sync, pin level per SYNC_POL
//   video_on     out  inside the visible 640x480 area
//   x, y         out  current pixel column / row
//   pix_stb      out  1-clk pulse: x/y/video_on just moved to a new pixel
//   line_start   out  pix_stb with new x == 0
//   frame_start  out  pix_stb with new (x,y) == (0,0)
//
// Build option VGA_SYNC_REG_EN: all outputs pass through one extra register
// stage (uniform 1-clk lag, mutual alignment unchanged). Without it the syncs
// and video_on are decoded combinationally from the counter/run registers.
// ---------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL,
    parameter int   CW       = VGA_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_clk,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pix_stb,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic          pix_clk_q;
    logic          tick;
    logic          run_q, run_d;
    logic          pix_stb_q, pix_stb_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          h_en, v_en;
    logic          h_wrap, v_wrap;
    logic          h_act, v_act;
    logic          h_sync, v_sync;
    logic [CW-1:0] h_cnt, v_cnt;

    logic          hsync_c, vsync_c, video_on_c;

    assign tick = pix_clk & ~pix_clk_q;
    assign h_en = tick & run_q;
    assign v_en = h_en & h_wrap;

    vga_axis_counter #(
        .CW        (CW),
        .TOTAL     (H_TOTAL),
        .ACTIVE    (H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_END  (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_cnt (
        .clk        (clk),
        .reset      (reset),
        .en_i       (h_en),
        .count_o    (h_cnt),
        .wrap_o     (h_wrap),
        .in_active_o(h_act),
        .in_sync_o  (h_sync)
    );

    vga_axis_counter #(
        .CW        (CW),
        .TOTAL     (V_TOTAL),
        .ACTIVE    (V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_END  (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_cnt (
        .clk        (clk),
        .reset      (reset),
        .en_i       (v_en),
        .count_o    (v_cnt),
        .wrap_o     (v_wrap),
        .in_active_o(v_act),
        .in_sync_o  (v_sync)
    );

    // The arming tick leaves the counters at (0,0), so it always counts as
    // both a line start and a frame start.
    always_comb begin
        run_d         = run_q | tick;
        pix_stb_d     = tick;
        line_start_d  = tick & (~run_q | h_wrap);
        frame_start_d = tick & (~run_q | (h_wrap & v_wrap));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_clk_q     <= 1'b0;
            run_q         <= 1'b0;
            pix_stb_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_clk_q     <= pix_clk;
            run_q         <= run_d;
            pix_stb_q     <= pix_stb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign video_on_c = run_q & h_act & v_act;
    assign hsync_c    = sync_level(run_q & h_sync, SYNC_POL);
    assign vsync_c    = sync_level(run_q & v_sync, SYNC_POL);

`ifdef VGA_SYNC_REG_EN
    logic          hsync_q, vsync_q, video_on_q;
    logic [CW-1:0] x_q, y_q;
    logic          pix_stb_o_q, line_start_o_q, frame_start_o_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q         <= ~SYNC_POL;
            vsync_q         <= ~SYNC_POL;
            video_on_q      <= 1'b0;
            x_q             <= '0;
            y_q             <= '0;
            pix_stb_o_q     <= 1'b0;
            line_start_o_q  <= 1'b0;
            frame_start_o_q <= 1'b0;
        end else begin
            hsync_q         <= hsync_c;
            vsync_q         <= vsync_c;
            video_on_q      <= video_on_c;
            x_q             <= h_cnt;
            y_q             <= v_cnt;
            pix_stb_o_q     <= pix_stb_q;
            line_start_o_q  <= line_start_q;
            frame_start_o_q <= frame_start_q;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign x           = x_q;
    assign y           = y_q;
    assign pix_stb     = pix_stb_o_q;
    assign line_start  = line_start_o_q;
    assign frame_start = frame_start_o_q;
`else
    assign hsync       = hsync_c;
    assign vsync       = vsync_c;
    assign video_on    = video_on_c;
    assign x           = h_cnt;
    assign y           = v_cnt;
    assign pix_stb     = pix_stb_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
`endif

endmodule
